seg_bus_decoder: RTL and testbench

Receive-side counterpart of the team's 7-segment display driver: monitors an 8-digit multiplexed segment bus (segment/dp byte plus common select), waits for each digit pattern to settle, decodes it back to a 4-bit hex value and decimal point, and publishes a complete 8-digit frame once every digit has been captured. Used as a bus checker/loopback receiver on the board and as the display-side model in system benches.

---
 rtl/seg_bus_decoder_if.sv | 21 ++
 rtl/seg_bus_decoder.sv | 137 +++++++++++++
 tb/tb_seg_bus_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/seg_bus_decoder_if.sv
// rtl/seg_bus_decoder_if.sv - multiplexed segment bus and decoded frame signals
interface seg_bus_decoder_if;
    logic [7:0]  seg_d;
    logic [7:0]  seg_com;
    logic [31:0] hex_out;
    logic [7:0]  dp_out;
    logic [7:0]  valid_out;
    logic        frame_done;
    logic        bad_pat;
    logic        idle;

    modport master (
        output seg_d, seg_com,
        input  hex_out, dp_out, valid_out, frame_done, bad_pat, idle
    );

    modport slave (
        input  seg_d, seg_com,
        output hex_out, dp_out, valid_out, frame_done, bad_pat, idle
    );
endinterface

// File: rtl/seg_bus_decoder.sv
// rtl/seg_bus_decoder.sv - 8-digit 7-segment bus receiver: settle, decode, assemble frames
module seg_bus_decoder #(
    parameter int STABLE_CYC     = 4,
    parameter int TIMEOUT_CYC    = 1000000,
    parameter bit COM_ACTIVE_LOW = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    seg_bus_decoder_if.slave  bus
);
    localparam logic [7:0]  STAB_MAX = 8'(STABLE_CYC);
    localparam logic [7:0]  STAB_PRE = 8'(STABLE_CYC - 1);
    localparam logic [23:0] TMO_MAX  = 24'(TIMEOUT_CYC);
    localparam logic [23:0] TMO_PRE  = 24'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_COLLECT = 2'd1} state_t;

    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3f: decode = 5'h10;
            7'h06: decode = 5'h11;
            7'h5b: decode = 5'h12;
            7'h4f: decode = 5'h13;
            7'h66: decode = 5'h14;
            7'h6d: decode = 5'h15;
            7'h7d: decode = 5'h16;
            7'h27: decode = 5'h17;
            7'h7f: decode = 5'h18;
            7'h6f: decode = 5'h19;
            7'h5f: decode = 5'h1a;
            7'h7c: decode = 5'h1b;
            7'h58: decode = 5'h1c;
            7'h5e: decode = 5'h1d;
            7'h7b: decode = 5'h1e;
            7'h71: decode = 5'h1f;
            default: decode = 5'h00;
        endcase
    endfunction

    state_t      state_q;
    logic [7:0]  seg_s1_q, seg_s2_q, com_s1_q, com_s2_q;
    logic [15:0] prev_q;
    logic [7:0]  stab_cnt_q, stab_cnt_d;
    logic [23:0] tmo_q, tmo_d;
    logic [31:0] hex_st_q, hex_q;
    logic [7:0]  dp_st_q, vld_st_q, mask_q, dp_q, vld_q;
    logic        frame_done_q, bad_pat_q, idle_q;

    logic [7:0]  sel;
    logic        same, one_hot, capture;
    logic [2:0]  cap_idx;
    logic [4:0]  dec;

    always_comb begin
        sel        = COM_ACTIVE_LOW ? ~com_s2_q : com_s2_q;
        same       = ({sel, seg_s2_q} == prev_q);
        one_hot    = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
        capture    = same && (stab_cnt_q == STAB_PRE) && one_hot;
        dec        = decode(seg_s2_q[6:0]);
        stab_cnt_d = !same ? 8'd0 : ((stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 8'd1);
        tmo_d      = capture ? 24'd0 : ((tmo_q == TMO_MAX) ? tmo_q : tmo_q + 24'd1);
        cap_idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) cap_idx = 3'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            com_s1_q     <= '0;
            com_s2_q     <= '0;
            prev_q       <= '0;
            stab_cnt_q   <= '0;
            tmo_q        <= '0;
            hex_st_q     <= '0;
            dp_st_q      <= '0;
            vld_st_q     <= '0;
            mask_q       <= '0;
            hex_q        <= '0;
            dp_q         <= '0;
            vld_q        <= '0;
            frame_done_q <= 1'b0;
            bad_pat_q    <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            seg_s1_q     <= bus.seg_d;
            seg_s2_q     <= seg_s1_q;
            com_s1_q     <= bus.seg_com;
            com_s2_q     <= com_s1_q;
            prev_q       <= {sel, seg_s2_q};
            stab_cnt_q   <= stab_cnt_d;
            tmo_q        <= tmo_d;
            frame_done_q <= 1'b0;
            bad_pat_q    <= 1'b0;
            if (capture) begin
                hex_st_q[{cap_idx, 2'b00} +: 4] <= dec[3:0];
                dp_st_q[cap_idx]  <= seg_s2_q[7];
                vld_st_q[cap_idx] <= dec[4];
                mask_q            <= mask_q | sel;
                bad_pat_q         <= !dec[4];
            end
            case (state_q)
                ST_IDLE: begin
                    if (capture) begin
                        state_q <= ST_COLLECT;
                        idle_q  <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    // Mask filled on the previous edge; the store already holds the last digit.
                    if (mask_q == 8'hff) begin
                        hex_q        <= hex_st_q;
                        dp_q         <= dp_st_q;
                        vld_q        <= vld_st_q;
                        frame_done_q <= 1'b1;
                        mask_q       <= capture ? sel : 8'd0;
                    end else if (!capture && tmo_q == TMO_PRE) begin
                        state_q <= ST_IDLE;
                        idle_q  <= 1'b1;
                        mask_q  <= 8'd0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.hex_out    = hex_q;
    assign bus.dp_out     = dp_q;
    assign bus.valid_out  = vld_q;
    assign bus.frame_done = frame_done_q;
    assign bus.bad_pat    = bad_pat_q;
    assign bus.idle       = idle_q;
endmodule

// File: tb/tb_seg_bus_decoder.sv
// tb/tb_seg_bus_decoder.sv - directed bench for seg_bus_decoder
module tb_seg_bus_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] seg_d = 8'h00;
    logic [7:0] seg_com = 8'hff;
    int         nvec = 0;
    int         nerr = 0;
    int         fd_a = 0, bd_a = 0, fd_t = 0;
    int         base, t0, t1;

    always #5 clk = ~clk;

    seg_bus_decoder_if bus_a ();
    seg_bus_decoder_if bus_t ();

    assign bus_a.seg_d   = seg_d;
    assign bus_a.seg_com = seg_com;
    assign bus_t.seg_d   = seg_d;
    assign bus_t.seg_com = seg_com;

    seg_bus_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(1000), .COM_ACTIVE_LOW(1'b1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );

    seg_bus_decoder #(.STABLE_CYC(4), .TIMEOUT_CYC(16), .COM_ACTIVE_LOW(1'b1)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t)
    );

    always @(posedge clk) begin
        fd_a <= fd_a + int'(bus_a.frame_done);
        bd_a <= bd_a + int'(bus_a.bad_pat);
        fd_t <= fd_t + int'(bus_t.frame_done);
    end

    function automatic logic [6:0] pat(input int h);
        case (h)
            0: pat = 7'h3f;  1: pat = 7'h06;  2: pat = 7'h5b;  3: pat = 7'h4f;
            4: pat = 7'h66;  5: pat = 7'h6d;  6: pat = 7'h7d;  7: pat = 7'h27;
            8: pat = 7'h7f;  9: pat = 7'h6f;  10: pat = 7'h5f; 11: pat = 7'h7c;
            12: pat = 7'h58; 13: pat = 7'h5e; 14: pat = 7'h7b; default: pat = 7'h71;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic blank(input int n);
        seg_com = 8'hff;
        seg_d   = 8'h00;
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int d, input logic [6:0] p, input logic dpb);
        seg_com = ~(8'h01 << d);
        seg_d   = {dpb, p};
        repeat (8) @(negedge clk);
        blank(2);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_hex", bus_a.hex_out, 32'h0);
        chk("rst_dp", {24'h0, bus_a.dp_out}, 32'h0);
        chk("rst_valid", {24'h0, bus_a.valid_out}, 32'h0);
        chk("rst_fd", {31'h0, bus_a.frame_done}, 32'h0);
        chk("rst_bad", {31'h0, bus_a.bad_pat}, 32'h0);
        chk("rst_idle", {31'h0, bus_a.idle}, 32'h1);
        rst = 1'b1;
        blank(2);

        for (int d = 0; d < 8; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("scan1_frames", 32'(fd_a), 32'd1);
        chk("scan1_hex", bus_a.hex_out, 32'h76543210);
        chk("scan1_valid", {24'h0, bus_a.valid_out}, 32'hff);
        chk("scan1_dp", {24'h0, bus_a.dp_out}, 32'h00);
        chk("scan1_idle", {31'h0, bus_a.idle}, 32'h0);
        chk("scan1_bad", 32'(bd_a), 32'd0);

        for (int d = 0; d < 8; d++) show(d, pat((d + 10) % 16), d == 3);
        blank(3);
        chk("scan2_frames", 32'(fd_a), 32'd2);
        chk("scan2_hex", bus_a.hex_out, 32'h10FEDCBA);
        chk("scan2_dp", {24'h0, bus_a.dp_out}, 32'h08);

        for (int d = 0; d < 4; d++) show(d, pat(d + 12), 1'b0);
        seg_com = ~8'h10;
        seg_d   = {1'b0, pat(4)};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_hex", bus_a.hex_out, 32'h0);
        chk("midrst_dp", {24'h0, bus_a.dp_out}, 32'h0);
        chk("midrst_valid", {24'h0, bus_a.valid_out}, 32'h0);
        chk("midrst_idle", {31'h0, bus_a.idle}, 32'h1);
        rst = 1'b1;
        blank(2);
        for (int d = 4; d < 8; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("postrst_partial", 32'(fd_a), 32'd2);
        for (int d = 0; d < 4; d++) show(d, pat(d + 8), 1'b0);
        blank(3);
        chk("postrst_frames", 32'(fd_a), 32'd3);
        chk("postrst_hex", bus_a.hex_out, 32'h7654BA98);

        show(0, pat(0), 1'b0);
        show(1, pat(1), 1'b0);
        seg_com = ~8'h04;
        seg_d   = 8'h5b;
        repeat (3) @(negedge clk);
        seg_d   = 8'h06;
        repeat (10) @(negedge clk);
        blank(2);
        for (int d = 3; d < 8; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("glitch_frames", 32'(fd_a), 32'd4);
        chk("glitch_hex", bus_a.hex_out, 32'h76543110);
        chk("glitch_bad", 32'(bd_a), 32'd0);

        show(0, 7'h00, 1'b0);
        show(1, 7'h55, 1'b0);
        for (int d = 2; d < 8; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("illegal_bad", 32'(bd_a), 32'd2);
        chk("illegal_frames", 32'(fd_a), 32'd5);
        chk("illegal_valid", {24'h0, bus_a.valid_out}, 32'hfc);
        chk("illegal_hex", bus_a.hex_out, 32'h76543200);

        for (int d = 0; d < 4; d++) show(d, pat(9 - d), 1'b0);
        seg_com = 8'b1111_1100;
        seg_d   = 8'h3f;
        repeat (20) @(negedge clk);
        blank(3);
        chk("multihot_frames", 32'(fd_a), 32'd5);
        chk("multihot_bad", 32'(bd_a), 32'd2);
        for (int d = 4; d < 8; d++) show(d, pat(9 - d), 1'b0);
        blank(3);
        chk("multihot_done", 32'(fd_a), 32'd6);
        chk("multihot_hex", bus_a.hex_out, 32'h23456789);

        blank(30);
        chk("tmo_idle_start", {31'h0, bus_t.idle}, 32'h1);
        base = fd_t;
        show(0, pat(0), 1'b0);
        chk("tmo_idle_cleared", {31'h0, bus_t.idle}, 32'h0);
        show(1, pat(1), 1'b0);
        seg_com = ~8'h04;
        seg_d   = 8'h00;
        t0 = -1;
        t1 = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus_t.bad_pat && t0 < 0) t0 = i;
            if (bus_t.idle && t1 < 0) t1 = i;
        end
        blank(2);
        chk("tmo_bad_seen", {31'h0, t0 >= 0}, 32'h1);
        chk("tmo_latency", 32'(t1 - t0), 32'd16);
        for (int d = 3; d < 8; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("tmo_no_frame", 32'(fd_t - base), 32'd0);
        chk("tmo_resume_idle", {31'h0, bus_t.idle}, 32'h0);
        for (int d = 0; d < 3; d++) show(d, pat(d), 1'b0);
        blank(3);
        chk("tmo_frame", 32'(fd_t - base), 32'd1);
        chk("tmo_hex", bus_t.hex_out, 32'h76543210);
        chk("tmo_valid", {24'h0, bus_t.valid_out}, 32'hff);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
